// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared event codes, FSM states and sizing helper for button_gesture
package button_pkg;

  typedef enum logic [1:0] {
    EV_CLICK  = 2'd0,
    EV_DOUBLE = 2'd1,
    EV_LONG   = 2'd2,
    EV_REPEAT = 2'd3
  } ev_code_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LHOLD  = 3'd4
  } gst_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_gesture_ev_slot.sv
// rtl/button_gesture_ev_slot.sv - one-entry valid/ready event holding register
// New events are dropped while the held one is stalled; drops set a sticky ovf.
module ev_slot
  import button_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  ev_code_t   push_code,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_code,
  output logic       ovf,
  input  logic       ovf_clr
);

  logic slot_free;

  // A slot being handed off this cycle can take the new event immediately.
  assign slot_free = ~ev_valid | ev_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_code  <= 2'd0;
      ovf      <= 1'b0;
    end else begin
      if (push && slot_free) begin
        ev_valid <= 1'b1;
        ev_code  <= push_code;
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end

      // A drop in the same cycle as a clear keeps ovf set.
      if (push && !slot_free) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_gesture.sv
// rtl/button_gesture.sv - classifies debounced presses into CLICK/DOUBLE/LONG/REPEAT events
module button_gesture
  import button_pkg::*;
#(
  parameter int LONG_TICKS   = 50_000_000,
  parameter int DBL_TICKS    = 25_000_000,
  parameter int REPEAT_TICKS = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_code,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       busy
);

  localparam int CW = $clog2(max3(LONG_TICKS, DBL_TICKS, REPEAT_TICKS));
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);

  gst_state_t    state;
  logic [CW-1:0] cnt;
  logic          btn_q;
  logic          rise;
  logic          emit;
  ev_code_t      emit_code;

  assign rise = btn & ~btn_q;
  assign busy = (state != IDLE);

  // Button changes are tested before terminal counts, so they win on boundary cycles.
  always_comb begin
    emit      = 1'b0;
    emit_code = EV_CLICK;
    case (state)
      PRESS1: begin
        if (btn && cnt == LONG_LAST) begin
          emit      = 1'b1;
          emit_code = EV_LONG;
        end
      end
      WAIT2: begin
        if (btn) begin
          emit      = 1'b1;
          emit_code = EV_DOUBLE;
        end else if (cnt == DBL_LAST) begin
          emit      = 1'b1;
          emit_code = EV_CLICK;
        end
      end
      LHOLD: begin
        if (btn && cnt == REP_LAST) begin
          emit      = 1'b1;
          emit_code = EV_REPEAT;
        end
      end
      default: begin
      end
    endcase
  end

  // btn_q resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      btn_q <= 1'b1;
    end else begin
      btn_q <= btn;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS1;
            cnt   <= '0;
          end
        end
        PRESS1: begin
          if (!btn) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state <= LHOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT2: begin
          if (btn) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == DBL_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESS2: begin
          if (!btn) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        LHOLD: begin
          if (!btn) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == REP_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  ev_slot u_slot (
    .clk       (clk),
    .rst       (rst),
    .push      (emit),
    .push_code (emit_code),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

endmodule
